// File: rtl/keyed_sib_lockout.sv
// keyed_sib_lockout: key-protected Segment Insertion Bit for an IJTAG network.
// The unlock key is scanned serially through a KEY_WIDTH key register in the
// SIB's own scan path. A wrong key on update counts as a failed attempt. After
// MAX_TRIES failures the block stays in LOCKOUT until RstBar is asserted.
// The protected segment is spliced in only when the block is UNLOCKED and the
// SIB bit is open.
// Optional feature: define AUTO_RELOCK_EN to relock after RELOCK_CYCLES idle
// clocks spent in UNLOCKED.
module keyed_sib_lockout #(
  parameter int unsigned          KEY_WIDTH     = 32,
  parameter logic [KEY_WIDTH-1:0] KEY_VALUE     = 32'h0034_1179,
  parameter int unsigned          MAX_TRIES     = 3,
  parameter int unsigned          RELOCK_CYCLES = 1024
) (
  input  logic       Clock,
  input  logic       RstBar,
  input  logic       SI,
  output logic       SO,
  input  logic       ShiftEN,
  input  logic       CaptureEN,
  input  logic       UpdateEn,
  input  logic       Select,
  input  logic       FromSO,
  output logic       ToSI,
  output logic       ToSelect,
  output logic       Locked,
  output logic       Lockout,
  output logic [7:0] FailCnt
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_TRIES);

  state_t               state;
  logic [KEY_WIDTH-1:0] key_sr;
  logic                 sib_sr;
  logic                 sib_upd;
  logic [7:0]           fail_cnt;

  logic       do_capture;
  logic       do_shift;
  logic       do_update;
  logic       unlocked;
  logic       path_open;
  logic       key_match;
  logic [7:0] fail_next;
  logic       relock_fire;

  // Only the highest-priority strobe acts, and only while selected.
  assign do_capture = Select & CaptureEN;
  assign do_shift   = Select & ShiftEN & ~CaptureEN;
  assign do_update  = Select & UpdateEn & ~CaptureEN & ~ShiftEN;

  assign unlocked  = (state == ST_UNLOCKED);
  assign path_open = unlocked & sib_upd;
  assign key_match = (key_sr == KEY_VALUE);
  assign fail_next = fail_cnt + 8'd1;

  // Scan path: SI always feeds the key register. The SIB bit takes either the
  // key register tail (closed) or the protected segment's return (open).
  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      key_sr <= '0;
      sib_sr <= 1'b0;
    end else if (do_capture) begin
      // Capture clears the key so the secret can never be shifted back out.
      key_sr <= '0;
      sib_sr <= sib_upd;
    end else if (do_shift) begin
      key_sr <= {SI, key_sr[KEY_WIDTH-1:1]};
      sib_sr <= path_open ? FromSO : key_sr[0];
    end
  end

`ifdef AUTO_RELOCK_EN
  localparam int unsigned RC_W = (RELOCK_CYCLES > 2) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [RC_W-1:0] RELOCK_LAST = RC_W'(RELOCK_CYCLES - 1);

  logic [RC_W-1:0] relock_cnt;
  logic            scan_active;

  assign scan_active = Select & (ShiftEN | CaptureEN | UpdateEn);
  assign relock_fire = unlocked & ~scan_active & (relock_cnt == RELOCK_LAST);

  // Idle counter: runs only while unlocked and restarts on any scan activity.
  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      relock_cnt <= '0;
    end else if (!unlocked || scan_active || relock_fire) begin
      relock_cnt <= '0;
    end else begin
      relock_cnt <= relock_cnt + 1'b1;
    end
  end
`else
  assign relock_fire = 1'b0;
`endif

  // Lock FSM: key check on update, failure counting, and permanent lockout.
  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      state    <= ST_LOCKED;
      sib_upd  <= 1'b0;
      fail_cnt <= 8'd0;
    end else if (do_update && (state != ST_LOCKOUT)) begin
      if (key_match) begin
        state    <= ST_UNLOCKED;
        fail_cnt <= 8'd0;
        sib_upd  <= sib_sr;
      end else begin
        sib_upd <= 1'b0;
        if (fail_next >= MAX_CNT) begin
          fail_cnt <= MAX_CNT;
          state    <= ST_LOCKOUT;
        end else begin
          fail_cnt <= fail_next;
          state    <= ST_LOCKED;
        end
      end
    end else if (relock_fire) begin
      state   <= ST_LOCKED;
      sib_upd <= 1'b0;
    end
  end

  assign SO       = sib_sr;
  assign ToSI     = key_sr[0];
  assign ToSelect = Select & sib_upd & unlocked;
  assign Locked   = ~unlocked;
  assign Lockout  = (state == ST_LOCKOUT);
  assign FailCnt  = fail_cnt;

endmodule

// File: tb/tb_keyed_sib_lockout.sv
// Directed testbench for keyed_sib_lockout (KEY_WIDTH=8, key 0xA5, 3 tries).
module tb_keyed_sib_lockout;

  logic       Clock = 1'b0;
  logic       RstBar = 1'b0;
  logic       SI = 1'b0;
  logic       SO;
  logic       ShiftEN = 1'b0;
  logic       CaptureEN = 1'b0;
  logic       UpdateEn = 1'b0;
  logic       Select = 1'b0;
  logic       FromSO = 1'b0;
  logic       ToSI;
  logic       ToSelect;
  logic       Locked;
  logic       Lockout;
  logic [7:0] FailCnt;

  int checks = 0;
  int errors = 0;

  keyed_sib_lockout #(
    .KEY_WIDTH    (8),
    .KEY_VALUE    (8'hA5),
    .MAX_TRIES    (3),
    .RELOCK_CYCLES(16)
  ) dut (
    .Clock    (Clock),
    .RstBar   (RstBar),
    .SI       (SI),
    .SO       (SO),
    .ShiftEN  (ShiftEN),
    .CaptureEN(CaptureEN),
    .UpdateEn (UpdateEn),
    .Select   (Select),
    .FromSO   (FromSO),
    .ToSI     (ToSI),
    .ToSelect (ToSelect),
    .Locked   (Locked),
    .Lockout  (Lockout),
    .FailCnt  (FailCnt)
  );

  always #5 Clock = ~Clock;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // Shift the SIB bit first, then the key LSB first: 9 shifts in total.
  task automatic scan_load(input logic [7:0] key, input logic sib);
    ShiftEN = 1'b1;
    SI = sib;
    cyc();
    for (int i = 0; i < 8; i++) begin
      SI = key[i];
      cyc();
    end
    ShiftEN = 1'b0;
    SI = 1'b0;
  endtask

  task automatic do_update();
    UpdateEn = 1'b1;
    cyc();
    UpdateEn = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (SO !== 1'b0) begin errors++; $display("FAIL reset_so got %b want 0", SO); end
    checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL reset_tosel got %b want 0", ToSelect); end
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL reset_locked got %b want 1", Locked); end
    checks++; if (Lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout got %b want 0", Lockout); end
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL reset_failcnt got %0d want 0", FailCnt); end
    RstBar = 1'b1;
    Select = 1'b1;
    cyc();
  endtask

  task automatic test_unlock();
    scan_load(8'hA5, 1'b1);
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL unlock_pre_locked got %b want 1", Locked); end
    do_update();
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL unlock_locked got %b want 0", Locked); end
    checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL unlock_tosel got %b want 1", ToSelect); end
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL unlock_failcnt got %0d want 0", FailCnt); end
    Select = 1'b0;
    #1;
    checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL unlock_tosel_desel got %b want 0", ToSelect); end
    Select = 1'b1;
    #1;
  endtask

  task automatic test_mismatch();
    FromSO = 1'b0;
    scan_load(8'h5A, 1'b1);
    do_update();
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL mis_locked got %b want 1", Locked); end
    checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL mis_tosel got %b want 0", ToSelect); end
    checks++; if (FailCnt !== 8'd1) begin errors++; $display("FAIL mis_failcnt got %0d want 1", FailCnt); end
    scan_load(8'hA5, 1'b1);
    do_update();
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL relog_failcnt got %0d want 0", FailCnt); end
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL relog_locked got %b want 0", Locked); end
    checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL relog_tosel got %b want 1", ToSelect); end
  endtask

  task automatic test_scan_clear();
    logic [8:0] pat;
    pat = 9'b1_0110_1001;
    CaptureEN = 1'b1;
    cyc();
    CaptureEN = 1'b0;
    checks++; if (SO !== 1'b1) begin errors++; $display("FAIL cap_sib_so got %b want 1", SO); end
    checks++; if (ToSI !== 1'b0) begin errors++; $display("FAIL cap_tosi got %b want 0", ToSI); end
    ShiftEN = 1'b1;
    SI = 1'b1;
    for (int k = 0; k < 9; k++) begin
      FromSO = pat[k];
      cyc();
      checks++; if (SO !== pat[k]) begin errors++; $display("FAIL open_so[%0d] got %b want %b", k, SO, pat[k]); end
      checks++;
      if (ToSI !== (k >= 7)) begin
        errors++; $display("FAIL open_tosi[%0d] got %b want %b", k, ToSI, (k >= 7));
      end
    end
    ShiftEN = 1'b0;
    SI = 1'b0;
    FromSO = 1'b0;
  endtask

  task automatic test_priority();
    // key register now holds 0xFF: an update that acted would be a failure.
    CaptureEN = 1'b1; UpdateEn = 1'b1;
    cyc();
    CaptureEN = 1'b0; UpdateEn = 1'b0;
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL prio_cap_failcnt got %0d want 0", FailCnt); end
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL prio_cap_locked got %b want 0", Locked); end
    ShiftEN = 1'b1; UpdateEn = 1'b1;
    cyc();
    ShiftEN = 1'b0; UpdateEn = 1'b0;
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL prio_shift_failcnt got %0d want 0", FailCnt); end
    Select = 1'b0; UpdateEn = 1'b1;
    cyc();
    UpdateEn = 1'b0; Select = 1'b1;
    #1;
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL desel_failcnt got %0d want 0", FailCnt); end
    checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL desel_tosel got %b want 1", ToSelect); end
  endtask

  task automatic test_lockout();
    for (int t = 1; t <= 3; t++) begin
      scan_load(8'h5A, 1'b1);
      do_update();
      checks++; if (FailCnt !== 8'(t)) begin errors++; $display("FAIL lock_failcnt[%0d] got %0d want %0d", t, FailCnt, t); end
    end
    checks++; if (Lockout !== 1'b1) begin errors++; $display("FAIL lock_lockout got %b want 1", Lockout); end
    scan_load(8'hA5, 1'b1);
    checks++; if (SO !== 1'b1) begin errors++; $display("FAIL lock_chain_so got %b want 1", SO); end
    do_update();
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL lock_locked got %b want 1", Locked); end
    checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL lock_tosel got %b want 0", ToSelect); end
    checks++; if (FailCnt !== 8'd3) begin errors++; $display("FAIL lock_failcnt_frozen got %0d want 3", FailCnt); end
    checks++; if (Lockout !== 1'b1) begin errors++; $display("FAIL lock_lockout_kept got %b want 1", Lockout); end
  endtask

  task automatic test_reset_midshift();
    ShiftEN = 1'b1;
    SI = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    RstBar = 1'b0;
    #1;
    checks++; if (Lockout !== 1'b0) begin errors++; $display("FAIL rst_lockout got %b want 0", Lockout); end
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL rst_failcnt got %0d want 0", FailCnt); end
    checks++; if (SO !== 1'b0) begin errors++; $display("FAIL rst_so got %b want 0", SO); end
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL rst_locked got %b want 1", Locked); end
    ShiftEN = 1'b0;
    SI = 1'b0;
    #2;
    RstBar = 1'b1;
    cyc();
    scan_load(8'hA5, 1'b1);
    do_update();
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL rst_unlock got %b want 0", Locked); end
    checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL rst_tosel got %b want 1", ToSelect); end
  endtask

  task automatic test_relock();
`ifdef AUTO_RELOCK_EN
    for (int i = 0; i < 15; i++) cyc();
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", Locked); end
    cyc();
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL relock_locked got %b want 1", Locked); end
    checks++; if (ToSelect !== 1'b0) begin errors++; $display("FAIL relock_tosel got %b want 0", ToSelect); end
    checks++; if (FailCnt !== 8'd0) begin errors++; $display("FAIL relock_failcnt got %0d want 0", FailCnt); end
`else
    for (int i = 0; i < 40; i++) cyc();
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL idle_locked got %b want 0", Locked); end
    checks++; if (ToSelect !== 1'b1) begin errors++; $display("FAIL idle_tosel got %b want 1", ToSelect); end
`endif
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_mismatch();
    test_scan_clear();
    test_priority();
    test_lockout();
    test_reset_midshift();
    test_relock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
